// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C slave register block.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam int   SYNC_STAGES  = 2;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronises one asynchronous bus line into clk and flags its edges.
// Everything resets to 1, matching an idle (pulled-up) I2C line.
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with a byte register file, oversampling SCL/SDA on clk.
// Supports pointer write, auto-incrementing writes and reads, repeated START.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b0001000,
    parameter int         NUM_REGS   = 16,
    localparam int        PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_sync_edge u_scl_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i2c_scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i2c_sda),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    i2c_state_e       state_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             rw_q;
    logic             ack_phase_q;
    logic             sda_oe_q;
    logic             sda_drv_q;
    logic             busy_q;
    logic             wr_strobe_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [7:0]       next_rd_byte;
    logic [7:0]       regs_q [NUM_REGS];

    assign shift_d      = {shift_q[6:0], sda_lvl};
    assign ptr_inc      = ptr_q + PTR_W'(1);
    assign next_rd_byte = regs_q[ptr_inc];

    // ack_phase_q splits each ACK state: 0 = waiting for the 8th SCL fall,
    // 1 = ACK bit on the bus, waiting for the 9th SCL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd7;
            shift_q     <= '0;
            rw_q        <= I2C_RW_WRITE;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            sda_drv_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ptr_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            sda_drv_q   <= sda_oe_q;
            if (start_evt) begin
                state_q     <= ADDR;
                bitcnt_q    <= 3'd7;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else if (stop_evt) begin
                state_q     <= IDLE;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        shift_q  <= shift_d;
                        bitcnt_q <= bitcnt_q - 3'd1;
                        if (bitcnt_q == 3'd0) begin
                            ack_phase_q <= 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (shift_d[7:1] == SLAVE_ADDR) begin
                                        state_q <= ADDR_ACK;
                                        rw_q    <= shift_d[0];
                                    end else begin
                                        state_q <= IDLE;
                                        busy_q  <= 1'b0;
                                    end
                                end
                                PTR: begin
                                    ptr_q   <= shift_d[PTR_W-1:0];
                                    state_q <= PTR_ACK;
                                end
                                default: begin
                                    regs_q[ptr_q] <= shift_d;
                                    wr_strobe_q   <= 1'b1;
                                    wr_addr_q     <= ptr_q;
                                    wr_data_q     <= shift_d;
                                    state_q       <= WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    RDATA: begin
                        bitcnt_q <= bitcnt_q - 3'd1;
                        if (bitcnt_q == 3'd0) begin
                            state_q     <= RDATA_ACK;
                            ack_phase_q <= 1'b0;
                        end
                    end
                    RDATA_ACK: begin
                        if (ack_phase_q && sda_lvl == I2C_NACK) begin
                            state_q     <= IDLE;
                            ack_phase_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    RDATA: begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        sda_oe_q <= ~shift_q[6];
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (!ack_phase_q) begin
                            sda_oe_q    <= 1'b1;
                            ack_phase_q <= 1'b1;
                            if (state_q == ADDR_ACK) begin
                                busy_q <= 1'b1;
                            end
                        end else begin
                            bitcnt_q    <= 3'd7;
                            ack_phase_q <= 1'b0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q == I2C_RW_READ) begin
                                        state_q  <= RDATA;
                                        shift_q  <= regs_q[ptr_q];
                                        sda_oe_q <= ~regs_q[ptr_q][7];
                                    end else begin
                                        state_q  <= PTR;
                                        sda_oe_q <= 1'b0;
                                    end
                                end
                                PTR_ACK: begin
                                    state_q  <= WDATA;
                                    sda_oe_q <= 1'b0;
                                end
                                default: begin
                                    state_q  <= WDATA;
                                    sda_oe_q <= 1'b0;
                                    ptr_q    <= ptr_inc;
                                end
                            endcase
                        end
                    end
                    RDATA_ACK: begin
                        if (!ack_phase_q) begin
                            sda_oe_q    <= 1'b0;
                            ack_phase_q <= 1'b1;
                        end else begin
                            state_q     <= RDATA;
                            ptr_q       <= ptr_inc;
                            shift_q     <= next_rd_byte;
                            sda_oe_q    <= ~next_rd_byte[7];
                            bitcnt_q    <= 3'd7;
                            ack_phase_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sda   = sda_drv_q ? 1'b0 : 1'bz;
    assign rd_data   = regs_q[rd_addr];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master plus a transaction-level
// model of the register file and pointer.
module tb_i2c_slave_regs;

    localparam logic [6:0] SADDR = 7'b0001000;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_low;
    wire        sda_bus;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave_regs #(.SLAVE_ADDR(SADDR), .NUM_REGS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2c_scl   (scl),
        .i2c_sda   (sda_bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register contents, pointer, expected write strobes.
    logic [7:0]  mregs [16];
    int          mptr;
    logic [11:0] expq [$];
    logic        quiet;
    logic        pin_en;
    logic [3:0]  pin_addr;
    logic [7:0]  wbuf [4];
    logic [7:0]  rbuf [4];
    logic [11:0] sb_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
            if (expq.size() == 0) begin
                chk("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
            end else begin
                sb_e = expq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(sb_e[11:8]));
                chk("wr_data", 32'(wr_data), 32'(sb_e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && quiet) begin
            chk("rd_data", 32'(rd_data), 32'(mregs[rd_addr]));
            chk("busy_idle", 32'(busy), 32'd0);
            chk("sda_idle", 32'(sda_bus), 32'd1);
        end
        rd_addr = pin_en ? pin_addr : 4'($urandom_range(0, 15));
    end

    task automatic pin(input logic [3:0] a, input logic [7:0] v, input string nm);
        pin_addr = a;
        pin_en   = 1'b1;
        w(2);
        chk(nm, 32'(rd_data), 32'(v));
        pin_en = 1'b0;
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            m_low = 1'b0; w(5);
            scl   = 1'b1; w(5);
        end
        m_low = 1'b1; w(5);
        scl   = 1'b0; w(5);
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_low = ~b; w(5);
        scl   = 1'b1; w(5);
        s     = sda_bus; w(5);
        scl   = 1'b0; w(5);
    endtask

    task automatic m_stop();
        m_low = 1'b1; w(5);
        scl   = 1'b1; w(5);
        m_low = 1'b0; w(10);
    endtask

    task automatic settle();
        w(8);
        quiet = 1'b1;
    endtask

    task automatic m_byte_w(input logic [7:0] b, output logic ackbit);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ackbit);
    endtask

    task automatic m_byte_r(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            b[i] = s;
        end
        m_bit(nack, s);
    endtask

    task automatic addr_phase(input logic rw);
        logic a;
        m_byte_w({SADDR, rw}, a);
        chk("addr_ack", 32'(a), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd1);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        logic a;
        m_byte_w(p, a);
        chk("ptr_ack", 32'(a), 32'd0);
        mptr = p % 16;
    endtask

    task automatic txn_write(input logic [7:0] p, input int n);
        logic a;
        quiet = 1'b0;
        m_start();
        addr_phase(1'b0);
        set_ptr(p);
        for (int i = 0; i < n; i++) begin
            expq.push_back({4'(mptr), wbuf[i]});
            mregs[mptr] = wbuf[i];
            m_byte_w(wbuf[i], a);
            chk("data_ack", 32'(a), 32'd0);
            mptr = (mptr + 1) % 16;
        end
        m_stop();
        settle();
    endtask

    task automatic txn_read(input int n, input logic setp, input logic [7:0] p);
        logic [7:0] b;
        quiet = 1'b0;
        m_start();
        if (setp) begin
            addr_phase(1'b0);
            set_ptr(p);
            m_start();
        end
        addr_phase(1'b1);
        for (int i = 0; i < n; i++) begin
            m_byte_r(i == n - 1, b);
            rbuf[i] = b;
            chk("rd_byte", 32'(b), 32'(mregs[mptr]));
            if (i != n - 1) mptr = (mptr + 1) % 16;
        end
        w(3);
        chk("sda_released_after_nack", 32'(sda_bus), 32'd1);
        m_stop();
        settle();
    endtask

    task automatic txn_bad(input logic [6:0] ad, input logic rw);
        logic a;
        quiet = 1'b0;
        m_start();
        m_byte_w({ad, rw}, a);
        chk("nack_on_mismatch", 32'(a), 32'd1);
        chk("busy_on_mismatch", 32'(busy), 32'd0);
        m_stop();
        settle();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 0;
        expq.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       s;
        logic [7:0] b;
        int         kind;
        int         n;
        logic [6:0] bad;

        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
        quiet = 1'b0; pin_en = 1'b0; pin_addr = 4'd0; rd_addr = 4'd0;
        model_reset();
        w(4);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        rst_n = 1'b1;
        settle();
        w(20);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        txn_write(8'h03, 2);
        pin(4'd3, 8'hA5, "lit_reg3_a5");
        pin(4'd4, 8'h5A, "lit_reg4_5a");
        chk("lit_last_wr_addr", 32'(wr_addr), 32'd4);
        chk("lit_last_wr_data", 32'(wr_data), 32'h5A);

        txn_bad(7'h09, 1'b0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(8'h0F, 2);
        pin(4'd15, 8'h11, "lit_reg15_wrap");
        pin(4'd0, 8'h22, "lit_reg0_wrap");
        wbuf[0] = 8'h77;
        txn_write(8'h13, 1);
        pin(4'd3, 8'h77, "lit_ptr13_is_3");

        txn_read(3, 1'b1, 8'h02);
        chk("lit_read0", 32'(rbuf[0]), 32'h00);
        chk("lit_read1", 32'(rbuf[1]), 32'h77);
        chk("lit_read2", 32'(rbuf[2]), 32'h5A);

        // STOP in the middle of a data byte
        quiet = 1'b0;
        m_start();
        addr_phase(1'b0);
        set_ptr(8'h06);
        for (int i = 0; i < 5; i++) m_bit(1'b1, s);
        m_stop();
        settle();
        pin(4'd6, 8'h00, "lit_partial_no_write");

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
                txn_write(8'($urandom_range(0, 255)), n);
            end else if (kind == 2) begin
                txn_read($urandom_range(1, 4), 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 255)));
            end else begin
                bad = 7'($urandom_range(0, 127));
                if (bad == SADDR) bad = 7'h09;
                txn_bad(bad, 1'($urandom_range(0, 1)));
            end
        end

        // Reset while the slave is driving a 0 read bit
        wbuf[0] = 8'h00;
        txn_write(8'h09, 1);
        quiet = 1'b0;
        m_start();
        addr_phase(1'b0);
        set_ptr(8'h09);
        m_start();
        addr_phase(1'b1);
        chk("read_bit_driven_low", 32'(sda_bus), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_sda_released", 32'(sda_bus), 32'd1);
        chk("rst_busy_mid", 32'(busy), 32'd0);
        chk("rst_wr_addr_mid", 32'(wr_addr), 32'd0);
        chk("rst_wr_data_mid", 32'(wr_data), 32'd0);
        chk("rst_wr_strobe_mid", 32'(wr_strobe), 32'd0);
        model_reset();
        w(2);
        scl = 1'b1;
        w(5);
        rst_n = 1'b1;
        settle();
        pin(4'd3, 8'h00, "lit_reg3_after_reset");
        w(40);
        wbuf[0] = 8'hC3;
        txn_write(8'h01, 1);
        txn_read(1, 1'b1, 8'h01);
        w(20);

        chk("strobes_all_seen", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
